// File: rtl/fixed_pkg.sv
// rtl/fixed_pkg.sv - shared fixed-point state type and saturation helpers
package fixed_pkg;

  typedef enum logic {ACC, HOLD} acc_state_t;

  // Intermediate width: holds any operand up to 63 bits plus a carry.
  localparam int WIDE_W = 65;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic  clamp;
    wide_t val;
  } satadd_t;

  function automatic wide_t smax(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t smin(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  function automatic satadd_t satadd(input wide_t a, input wide_t b, input int w);
    wide_t   s;
    satadd_t r;
    s       = a + b;
    r.clamp = 1'b0;
    r.val   = s;
    if (s > smax(w)) begin
      r.clamp = 1'b1;
      r.val   = smax(w);
    end else if (s < smin(w)) begin
      r.clamp = 1'b1;
      r.val   = smin(w);
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_signed.sv
// rtl/sat_signed.sv - clamps a signed IN_W value into the signed OUT_W range
module sat_signed
  import fixed_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] HI = IN_W'(smax(OUT_W));
  localparam logic signed [IN_W-1:0] LO = IN_W'(smin(OUT_W));

  logic signed [IN_W-1:0] d;

  assign d = $signed(din);

  always_comb begin
    dout = d[OUT_W-1:0];
    if (d > HI) begin
      dout = HI[OUT_W-1:0];
    end else if (d < LO) begin
      dout = LO[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/acc_dump.sv
// rtl/acc_dump.sv - integrate-and-dump decimator with saturating wide accumulator
module acc_dump
  import fixed_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int N_W   = 8,
  parameter int SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [N_W-1:0]   dump_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             acc_ovf
);

  acc_state_t state, state_n;

  logic signed [ACC_W-1:0] acc, acc_next, shifted;
  logic [N_W-1:0]          cnt, len_q, len_eff, last_idx;
  logic                    ovf_q, add_clamp, accept, last;
  logic [OUT_W-1:0]        narrow;

  // Packs the package helper's result down to {clamp, ACC_W-bit sum}.
  function automatic logic [ACC_W:0] add_sat(input logic [ACC_W-1:0] a,
                                              input logic [IN_W-1:0]  b);
    satadd_t r;
    r = satadd(wide_t'($signed(a)), wide_t'($signed(b)), ACC_W);
    return {r.clamp, r.val[ACC_W-1:0]};
  endfunction

  assign {add_clamp, acc_next} = add_sat(acc, in_data);

  // The first sample of a frame sees dump_len live; later ones use the latched copy.
  assign len_eff  = (cnt == '0) ? dump_len : len_q;
  assign last_idx = (len_eff == '0) ? '0 : len_eff - N_W'(1);
  assign last     = (cnt == last_idx);

  assign in_ready  = (state == ACC) && !clear && !rst;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign shifted   = acc_next >>> SHIFT;

  sat_signed #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_sat (
    .din  (shifted),
    .dout (narrow)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ACC:     if (accept && last) state_n = HOLD;
      HOLD:    if (out_ready) state_n = ACC;
      default: state_n = ACC;
    endcase
    if (clear) state_n = ACC;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
      acc_ovf  <= 1'b0;
    end else if (clear || (out_valid && out_ready)) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      acc   <= acc_next;
      ovf_q <= ovf_q | add_clamp;
      if (cnt == '0) len_q <= dump_len;
      // cnt holds on the final sample so it never exceeds 2^N_W-2.
      if (last) begin
        out_data <= narrow;
        out_sat  <= (narrow != shifted[OUT_W-1:0]);
        acc_ovf  <= ovf_q | add_clamp;
      end else begin
        cnt <= cnt + N_W'(1);
      end
    end
  end

endmodule

// File: doc/acc_dump.md
# acc_dump

Integrate-and-dump decimator for the fixed-point control datapath. It accepts a stream of signed IN_W samples, sign-extends them into a wide ACC_W accumulator with saturating addition, and emits one narrowed OUT_W result per frame of `dump_len` samples. It is the widening counterpart of the `sat_signed` narrowing helper, which it instantiates for the final ACC_W→OUT_W clamp. It sits between ADC sample conditioning and the control-loop update stage.

## Interface
- `IN_W`, 16, sample width (signed)
- `ACC_W`, 32, accumulator width (signed); must be > IN_W and ≥ OUT_W
- `OUT_W`, 16, result width (signed)
- `N_W`, 8, width of `dump_len`
- `SHIFT`, 0, arithmetic right shift applied to the accumulator before narrowing; range 0..ACC_W-OUT_W

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `clear`  in  1  synchronous frame abort
- `dump_len`  in  N_W  samples per frame, unsigned; latched on the first accepted sample of each frame
- `in_valid`  in  1  sample valid
- `in_ready`  out  1  sample accepted when `in_valid && in_ready`
- `in_data`  in  IN_W  signed sample
- `out_valid`  out  1  result valid; held until accepted
- `out_ready`  in  1  result consumed when `out_valid && out_ready`
- `out_data`  out  OUT_W  signed narrowed result
- `out_sat`  out  1  the narrowing of this result clamped
- `acc_ovf`  out  1  the accumulator saturated at least once during this frame

## Operation
- FSM states: ACC (collecting) and HOLD (result presented).
- ACC:
  - `in_ready = !clear`.
  - On accept: `acc <= satadd(acc, sext(in_data))` and `cnt <= cnt+1`.
  - `len_q` latches `dump_len` when `cnt == 0`. `dump_len == 0` is treated as 1.
- satadd:
  - Compute the sum at ACC_W+1 bits.
  - Clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Set the sticky frame flag `ovf_q` on clamp.
- End of frame: on accepting sample number `len_q` (`cnt == len_q-1`, using `dump_len` itself when `cnt == 0`):
  - Register `out_data = sat_signed(acc_next >>> SHIFT)`, where `>>>` floors.
  - Register `out_sat` = narrowing clamped.
  - Register `acc_ovf = ovf_q | this-add clamp`.
  - Go to HOLD.
- HOLD:
  - `in_ready = 0`, `out_valid = 1`.
  - `out_data`, `out_sat` and `acc_ovf` are stable until the handshake.
  - On `out_ready`: set `acc = 0`, `cnt = 0`, `ovf_q = 0`, `out_valid = 0`, and return to ACC.
- `clear` (any state):
  - Next cycle: `acc = 0`, `cnt = 0`, `ovf_q = 0`, `out_valid = 0`, state ACC.
  - A pending result is discarded.
  - A sample presented in the same cycle is not accepted (`in_ready` is low).
- Priority: `rst` > `clear` > handshakes.

## Timing
- Reset values: state ACC, `acc = 0`, `cnt = 0`, `out_valid = 0`, `out_data = 0`, `out_sat = 0`, `acc_ovf = 0`.
- `in_ready` is 0 during the `rst` cycle and 1 in the first cycle after it.
- Latency: `out_valid` rises in the cycle after the last sample of a frame is accepted.
- Throughput: at most one sample per cycle. Minimum frame period is `len+1` cycles, because the first sample of the next frame is accepted no earlier than the cycle after the output handshake.
- Backpressure: `out_ready` low holds HOLD indefinitely. No sample is accepted or lost meanwhile.
- `dump_len` changes mid-frame have no effect until the next frame.
- `rst` mid-frame or in HOLD: all state returns to its reset values on the next edge.
- `cnt` never wraps; its maximum value is 2^N_W-2.

## Structure
- Shared package `fixed_pkg`:
  - state enum `acc_state_t` {ACC, HOLD}
  - `satadd` function (parameterised by width via a localparam wrapper or an inline helper)
  - saturation bound helper constants reused by the datapath
- Sub-module: one `sat_signed #(.IN_W(ACC_W), .OUT_W(OUT_W))` for the final narrowing. `out_sat` is derived by comparing its output against the shifted value truncated to OUT_W.
- Everything else (FSM, counter, accumulator, output registers) is a single module.

## Test plan
- Basic sum, defaults: `dump_len = 4`, samples 100, 200, -50, 10 → `out_data = 260`, `out_sat = 0`, `acc_ovf = 0`. `out_valid` rises the cycle after the 4th accept.
- Narrowing clamp: `dump_len = 2`, samples 30000, 30000 → `out_data = 32767`, `out_sat = 1`, `acc_ovf = 0`. Repeat with -30000, -30000 → `out_data = -32768`, `out_sat = 1`.
- Accumulator clamp, `ACC_W = 20`: `dump_len = 20`, all samples 32767 → acc clamps to 524287, `acc_ovf = 1`, `out_data = 32767`, `out_sat = 1`. The next frame of 1, 1 gives `out_data = 2` and `acc_ovf = 0`.
- Shift, `SHIFT = 2`: `dump_len = 1`, sample -5 → `out_data = -2`.
- Backpressure: hold `out_ready` low for 5 cycles while `in_valid = 1` → `out_data` stable and `in_ready = 0` throughout. After the handshake the next frame sums exactly the subsequent samples.
- Clear, zero length and reset:
  - `clear` after 2 of 4 samples (7, 7), then samples 1, 2, 3, 4 → `out_data = 10`.
  - `dump_len = 0` with sample 9 → `out_data = 9` after one sample.
  - `rst` asserted in HOLD → `out_valid = 0` and `out_data = 0` on the next cycle.
